// File: rtl/sccb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// sccb_bus_arbiter
//
// Shares a single I2C/SCCB driver between NUM_REQ register-access clients
// (boot-time init sequencer, auto-exposure tuning, debug port, ...).
// Idle requests are granted round-robin. The winner's command is latched and
// handed to the driver. The arbiter then sequences the driver's load/complete
// handshake, captures read data and pulses a one-cycle acknowledge to the owner.
//
// Optional feature (macro SCCB_ARB_TIMEOUT_EN):
//   When the macro is defined, a watchdog counts clk cycles from grant through
//   LOAD and WAIT. When the count reaches TIMEOUT_CYCLES, the transaction is
//   abandoned and err/ack pulse together. When the macro is undefined, err is
//   tied to 0 and the arbiter waits indefinitely for the driver.
//
// Parameters:
//   NUM_REQ         number of requesting clients (2..8)
//   TIMEOUT_CYCLES  watchdog limit in clk cycles (timeout build only)
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   req            per-client request, held until ack
//   req_rw         per-client direction, 1 = read
//   req_data       client i in [16i+15:16i]: [15:8] reg addr, [7:0] wr data
//   grant          one-hot owner of the driver, 0 when idle
//   ack            one-cycle completion pulse to the owner
//   err            one-cycle timeout pulse, coincident with ack
//   rd_data        last read result
//   busy           FSM not in IDLE
//   drv_start      start/load request to the driver
//   drv_rw         latched direction to the driver
//   drv_data       latched address/data to the driver
//   drv_load_comp  driver accepted the command
//   drv_task_comp  driver finished the bus transaction
//   drv_rdata      driver read byte, valid with drv_task_comp
// -----------------------------------------------------------------------------
module sccb_bus_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_rw,
  input  logic [16*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     ack,
  output logic [NUM_REQ-1:0]     err,
  output logic [7:0]             rd_data,
  output logic                   busy,
  output logic                   drv_start,
  output logic                   drv_rw,
  output logic [15:0]            drv_data,
  input  logic                   drv_load_comp,
  input  logic                   drv_task_comp,
  input  logic [7:0]             drv_rdata
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W+1)'(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("sccb_bus_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_RELEASE
  } state_e;

  state_e               state_q;
  logic [PTR_W-1:0]     ptr_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [NUM_REQ-1:0]   ack_q;
  logic                 drv_rw_q;
  logic [15:0]          drv_data_q;
  logic [7:0]           rd_data_q;

  // ---------------------------------------------------------------------------
  // Round-robin selection: first set req bit strictly after ptr_q, wrapping.
  // Scanning k = 1..NUM_REQ visits every client exactly once, so the previous
  // winner is considered last.
  // ---------------------------------------------------------------------------
  logic                 win_valid_d;
  logic [PTR_W-1:0]     win_idx_d;
  logic [PTR_W:0]       cand_sum;
  logic [NUM_REQ-1:0]   win_onehot_d;
  logic [15:0]          win_cmd_d;

  // NOTE: every signal assigned in always_comb gets a default at the top so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    win_valid_d = 1'b0;
    win_idx_d   = ptr_q;
    cand_sum    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (cand_sum >= NUM_REQ_W) cand_sum = cand_sum - NUM_REQ_W;
      if (!win_valid_d && req[cand_sum[PTR_W-1:0]]) begin
        win_valid_d = 1'b1;
        win_idx_d   = cand_sum[PTR_W-1:0];
      end
    end
  end

  assign win_onehot_d = NUM_REQ'(1) << win_idx_d;
  assign win_cmd_d    = req_data[{win_idx_d, 4'b0000} +: 16];

  // A normal completion: task_comp in WAIT, or both handshakes together in
  // LOAD. task_comp alone in LOAD is deliberately not a completion.
  logic done_ok;
  assign done_ok = ((state_q == ST_LOAD) && drv_load_comp && drv_task_comp) ||
                   ((state_q == ST_WAIT) && drv_task_comp);

  // Abandon the transaction on watchdog expiry (never fires without the macro).
  logic tmo_fire;

`ifdef SCCB_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0]   tmo_cnt_q;
  logic [NUM_REQ-1:0] err_q;

  // The counter is 0 in the first LOAD cycle. Firing at TIMEOUT_CYCLES-1 puts
  // RELEASE exactly TIMEOUT_CYCLES cycles after the grant.
  assign tmo_fire = ((state_q == ST_LOAD) || (state_q == ST_WAIT)) && !done_ok &&
                    (tmo_cnt_q >= TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      err_q     <= '0;
    end else begin
      err_q <= tmo_fire ? grant_q : '0;
      if ((state_q == ST_LOAD) || (state_q == ST_WAIT)) begin
        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
      end else begin
        tmo_cnt_q <= '0;
      end
    end
  end

  assign err = err_q;
`else
  assign tmo_fire = 1'b0;
  assign err      = '0;
`endif

  // ---------------------------------------------------------------------------
  // Main FSM. grant, ack and the latched command are registered here.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= only, so every register samples
  // the values from before the edge, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= PTR_W'(NUM_REQ - 1);
      grant_q    <= '0;
      ack_q      <= '0;
      drv_rw_q   <= 1'b0;
      drv_data_q <= '0;
      rd_data_q  <= '0;
    end else begin
      ack_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (win_valid_d) begin
            grant_q    <= win_onehot_d;
            drv_rw_q   <= req_rw[win_idx_d];
            drv_data_q <= win_cmd_d;
            ptr_q      <= win_idx_d;
            state_q    <= ST_LOAD;
          end
        end

        ST_LOAD, ST_WAIT: begin
          if (done_ok || tmo_fire) begin
            // A timed-out read leaves rd_data untouched.
            if (done_ok && drv_rw_q) rd_data_q <= drv_rdata;
            ack_q   <= grant_q;
            state_q <= ST_RELEASE;
          end else if ((state_q == ST_LOAD) && drv_load_comp) begin
            state_q <= ST_WAIT;
          end
        end

        ST_RELEASE: begin
          grant_q <= '0;
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant     = grant_q;
  assign ack       = ack_q;
  assign rd_data   = rd_data_q;
  assign busy      = (state_q != ST_IDLE);
  assign drv_start = (state_q == ST_LOAD);
  assign drv_rw    = drv_rw_q;
  assign drv_data  = drv_data_q;

endmodule

// File: tb/tb_sccb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sccb_bus_arbiter
//
// Bench for sccb_bus_arbiter with NUM_REQ = 3, default build without timeout.
// A transaction-level reference model (owner, loaded flag, release flag,
// round-robin pointer) predicts grant/ack/busy/drv_* and rd_data every cycle.
// Outputs are sampled on the falling edge, and new stimulus is applied there.
// Scenarios covered: reset, directed write and read, simultaneous handshakes,
// contention order, randomized traffic with spurious task_comp, and reset
// asserted mid-operation.
// -----------------------------------------------------------------------------
module tb_sccb_bus_arbiter;

  localparam int N = 3;

  typedef enum int {M_DIRECTED, M_HOLD, M_RAND} cmode_e;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N-1:0]     req_rw;
  logic [16*N-1:0]  req_data;
  logic [N-1:0]     grant;
  logic [N-1:0]     ack;
  logic [N-1:0]     err;
  logic [7:0]       rd_data;
  logic             busy;
  logic             drv_start;
  logic             drv_rw;
  logic [15:0]      drv_data;
  logic             drv_load_comp;
  logic             drv_task_comp;
  logic [7:0]       drv_rdata;

  sccb_bus_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(65535)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_rw        (req_rw),
    .req_data      (req_data),
    .grant         (grant),
    .ack           (ack),
    .err           (err),
    .rd_data       (rd_data),
    .busy          (busy),
    .drv_start     (drv_start),
    .drv_rw        (drv_rw),
    .drv_data      (drv_data),
    .drv_load_comp (drv_load_comp),
    .drv_task_comp (drv_task_comp),
    .drv_rdata     (drv_rdata)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  int         m_owner;   // -1 when nobody owns the driver
  bit         m_idle;
  bit         m_loaded;  // driver accepted the command
  bit         m_rel;     // current cycle is the ack cycle
  int         m_ptr;
  logic [7:0] m_rd;
  logic       m_rw;
  logic [15:0] m_data;
  int         m_done;
  int         gseq[$];

  // ---------------- stimulus policy ----------------
  cmode_e     mode;
  int         remaining [N];
  int         ack_seen  [N];
  bit         rand_drv;
  bit         spurious;
  bit         both;
  int         load_lat;
  int         task_lat;
  int         d_cnt;
  logic [7:0] fixed_rdata;

  task automatic model_reset();
    m_owner  = -1;
    m_idle   = 1'b1;
    m_loaded = 1'b0;
    m_rel    = 1'b0;
    m_ptr    = N - 1;
    m_rd     = 8'h00;
    m_rw     = 1'b0;
    m_data   = 16'h0000;
    d_cnt    = 0;
  endtask

  // Advance the model over the rising edge that just happened, using the
  // inputs that were applied before that edge.
  task automatic model_update();
    bit complete;
    complete = 1'b0;
    if (m_idle) begin
      if (req != '0) begin
        for (int k = 1; k <= N; k++) begin
          if (req[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N;
            break;
          end
        end
        m_ptr    = m_owner;
        m_idle   = 1'b0;
        m_loaded = 1'b0;
        m_rw     = req_rw[m_owner];
        m_data   = req_data[16*m_owner +: 16];
        d_cnt    = 0;
        gseq.push_back(m_owner);
        if (rand_drv) begin
          load_lat = $urandom_range(0, 4);
          task_lat = $urandom_range(0, 6);
          both     = ($urandom_range(0, 3) == 0);
        end
      end
    end else if (m_rel) begin
      m_rel   = 1'b0;
      m_idle  = 1'b1;
      m_owner = -1;
      m_done++;
    end else begin
      if (!m_loaded) begin
        if (drv_load_comp) begin
          if (drv_task_comp) complete = 1'b1;
          else begin
            m_loaded = 1'b1;
            d_cnt    = 0;
          end
        end
      end else if (drv_task_comp) begin
        complete = 1'b1;
      end
      if (complete) begin
        if (m_rw) m_rd = drv_rdata;
        m_rel = 1'b1;
      end
    end
  endtask

  task automatic compare();
    logic [N-1:0] eg;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    check("grant",     32'(grant),     32'(eg));
    check("ack",       32'(ack),       m_rel ? 32'(eg) : 32'd0);
    check("err",       32'(err),       32'd0);
    check("busy",      32'(busy),      32'(!m_idle));
    check("drv_start", 32'(drv_start), 32'(!m_idle && !m_loaded && !m_rel));
    check("rd_data",   32'(rd_data),   32'(m_rd));
    if (m_owner >= 0) begin
      check("drv_data", 32'(drv_data), 32'(m_data));
      check("drv_rw",   32'(drv_rw),   32'(m_rw));
    end
    for (int i = 0; i < N; i++) ack_seen[i] += int'(ack[i]);
  endtask

  task automatic drive();
    drv_load_comp = 1'b0;
    drv_task_comp = 1'b0;
    drv_rdata     = rand_drv ? 8'($urandom) : fixed_rdata;
    if (!m_idle && !m_rel) begin
      if (!m_loaded) begin
        if (d_cnt >= load_lat) begin
          drv_load_comp = 1'b1;
          drv_task_comp = both;
        end else if (spurious && $urandom_range(0, 7) == 0) begin
          drv_task_comp = 1'b1;  // must be ignored while still in LOAD
        end
      end else if (d_cnt >= task_lat) begin
        drv_task_comp = 1'b1;
      end
      d_cnt++;
    end
    for (int i = 0; i < N; i++) begin
      if (mode == M_HOLD) begin
        req[i] = 1'b1;
      end else if (req[i] && m_rel && m_owner == i) begin
        req[i] = 1'b0;
      end else if (mode == M_RAND && !req[i] && remaining[i] > 0 &&
                   $urandom_range(0, 3) == 0) begin
        req[i]              = 1'b1;
        req_rw[i]           = 1'($urandom);
        req_data[16*i +: 16] = 16'($urandom);
        remaining[i]--;
      end else if (mode == M_RAND && req[i] && m_owner == i) begin
        // The command is latched, so scrambling it after grant must not matter.
        req_rw[i]           = 1'($urandom);
        req_data[16*i +: 16] = 16'($urandom);
      end
    end
  endtask

  task automatic do_cycle();
    @(negedge clk);
    model_update();
    compare();
    drive();
  endtask

  task automatic clear_ack_seen();
    for (int i = 0; i < N; i++) ack_seen[i] = 0;
  endtask

  // Run until one more transaction has finished, or the budget expires.
  task automatic run_one_txn(input string tag, input int budget);
    int start_done;
    int n;
    start_done = m_done;
    n = 0;
    while (m_done == start_done && n < budget) begin
      do_cycle();
      n++;
    end
    check(tag, 32'(m_done > start_done), 32'd1);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    int left;
    n = 0;
    left = 1;
    while (left != 0 && n < budget) begin
      do_cycle();
      n++;
      left = 0;
      for (int i = 0; i < N; i++) left += remaining[i];
      if (!m_idle || req != '0) left++;
    end
    check(tag, 32'(left), 32'd0);
  endtask

  initial begin
    int n;
    int base;
    rst           = 1'b1;
    req           = '0;
    req_rw        = '0;
    req_data      = '0;
    drv_load_comp = 1'b0;
    drv_task_comp = 1'b0;
    drv_rdata     = 8'h00;
    mode          = M_DIRECTED;
    rand_drv      = 1'b0;
    spurious      = 1'b0;
    both          = 1'b0;
    load_lat      = 0;
    task_lat      = 0;
    fixed_rdata   = 8'h00;
    m_done        = 0;
    for (int i = 0; i < N; i++) remaining[i] = 0;
    clear_ack_seen();
    model_reset();

    // ---------- reset state ----------
    repeat (2) @(negedge clk);
    check("rst_grant",     32'(grant),     32'd0);
    check("rst_ack",       32'(ack),       32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_drv_start", 32'(drv_start), 32'd0);
    check("rst_drv_rw",    32'(drv_rw),    32'd0);
    check("rst_drv_data",  32'(drv_data),  32'd0);
    check("rst_rd_data",   32'(rd_data),   32'd0);
    rst = 1'b0;

    // ---------- single write, client 1 ----------
    clear_ack_seen();
    load_lat = 4; task_lat = 20; both = 1'b0;
    req[1] = 1'b1; req_rw[1] = 1'b0; req_data[16 +: 16] = 16'h1280;
    run_one_txn("wr_done", 100);
    check("wr_ack_count", 32'(ack_seen[1]), 32'd1);
    check("wr_rd_data",   32'(rd_data),     32'h00);

    // ---------- single read, client 0 ----------
    clear_ack_seen();
    load_lat = 2; task_lat = 5; fixed_rdata = 8'h76;
    req[0] = 1'b1; req_rw[0] = 1'b1; req_data[0 +: 16] = 16'h0A00;
    run_one_txn("rd_done", 100);
    check("rd_ack_count", 32'(ack_seen[0]), 32'd1);
    check("rd_rd_data",   32'(rd_data),     32'h76);

    // ---------- simultaneous load_comp + task_comp, client 2 ----------
    clear_ack_seen();
    load_lat = 1; both = 1'b1; fixed_rdata = 8'h3C;
    req[2] = 1'b1; req_rw[2] = 1'b1; req_data[32 +: 16] = 16'h3412;
    run_one_txn("sim_done", 50);
    check("sim_ack_count", 32'(ack_seen[2]), 32'd1);
    check("sim_rd_data",   32'(rd_data),     32'h3C);
    both = 1'b0;

    // ---------- contention: all clients hold req ----------
    gseq.delete();
    mode = M_HOLD; load_lat = 1; task_lat = 2;
    n = 0;
    while (gseq.size() < 6 && n < 300) begin
      do_cycle();
      n++;
    end
    check("hold_grants", 32'(gseq.size() >= 6), 32'd1);
    for (int k = 0; k < 6 && k < gseq.size(); k++) begin
      check($sformatf("hold_order%0d", k), 32'(gseq[k]), 32'(k % 3));
    end
    mode = M_DIRECTED;
    drain("hold_drain", 300);

    // ---------- randomized traffic ----------
    mode = M_RAND; rand_drv = 1'b1; spurious = 1'b1;
    for (int i = 0; i < N; i++) remaining[i] = 12;
    drain("rand_drain", 8000);
    mode = M_DIRECTED; rand_drv = 1'b0; spurious = 1'b0;

    // ---------- reset during WAIT with client 2 granted ----------
    load_lat = 1; task_lat = 40; fixed_rdata = 8'hE7;
    req[2] = 1'b1; req_rw[2] = 1'b1; req_data[32 +: 16] = 16'h5A5A;
    n = 0;
    while (!(m_owner == 2 && m_loaded) && n < 50) begin
      do_cycle();
      n++;
    end
    check("mid_reached_wait", 32'(m_owner == 2 && m_loaded), 32'd1);
    repeat (2) do_cycle();
    base = int'(rd_data);
    rst = 1'b1;
    #1;
    check("mid_grant",     32'(grant),     32'd0);
    check("mid_drv_start", 32'(drv_start), 32'd0);
    check("mid_busy",      32'(busy),      32'd0);
    check("mid_rd_data",   32'(rd_data),   32'd0);
    model_reset();
    req = '0;
    drv_load_comp = 1'b0;
    drv_task_comp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    req = 3'b111;
    load_lat = 0; task_lat = 1;
    gseq.delete();
    n = 0;
    while (gseq.size() == 0 && n < 20) begin
      do_cycle();
      n++;
    end
    check("post_rst_grant_seen", 32'(gseq.size()), 32'd1);
    if (gseq.size() > 0) check("post_rst_winner", 32'(gseq[0]), 32'd0);
    drain("post_rst_drain", 300);
    if (base < 0) $display("unreachable");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
